// File: rtl/bayer_bin_stream_ctrl.sv
// Line-buffered stream sequencer for 2x2 Bayer binning: pairs each pixel with the pixel
// above it and emits column/row parity plus valid strobes aligned to the binning datapath.
module bayer_bin_stream_ctrl #(
    parameter int unsigned MAX_WIDTH = 1024,
    parameter int unsigned COL_W     = 10,
    parameter int unsigned ROW_W     = 12,
    parameter bit          X_PHASE   = 1'b0,
    parameter bit          Y_PHASE   = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             iFVAL,
    input  logic             iDVAL,
    input  logic [9:0]       iDATA,
    output logic [9:0]       oD0,
    output logic [9:0]       oD1,
    output logic             oX,
    output logic             oY,
    output logic             oBIN_VAL,
    output logic             oRGB_VAL,
    output logic             oFRAME_START,
    output logic [ROW_W-1:0] oROW,
    output logic             oOVF
);

    localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    // One extra bit so the column count can sit at MAX_WIDTH without wrapping.
    localparam int unsigned CW = COL_W + 1;
    localparam logic [CW-1:0] ColMax = CW'(MAX_WIDTH);

    typedef enum logic [1:0] {StIdle, StArmed, StFirst, StActive} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             ovf_q, ovf_d;
    logic             fval_q, fval_d;
    logic             dval_q, dval_d;
    logic [9:0]       d0_q, d0_d;
    logic [9:0]       d1_q, d1_d;
    logic             x_q, x_d;
    logic             y_q, y_d;
    logic             bin_q, bin_d;
    logic             rgb_q, rgb_d;
    logic             fs_q, fs_d;

    logic [9:0]       line_mem [MAX_WIDTH];
    logic [AW-1:0]    addr;
    logic [9:0]       mem_rd;
    logic             wr_en;
    logic             dv;
    logic             in_line;
    logic             in_frame;

    assign dv       = iDVAL & iFVAL;
    assign addr     = col_q[AW-1:0];
    assign mem_rd   = line_mem[addr];
    assign in_line  = (col_q < ColMax);
    assign in_frame = (state_q == StFirst) || (state_q == StActive);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ovf_d   = ovf_q;
        fval_d  = iFVAL;
        dval_d  = dv & in_frame;
        d0_d    = d0_q;
        d1_d    = d1_q;
        x_d     = x_q;
        y_d     = y_q;
        bin_d   = 1'b0;
        rgb_d   = bin_q;
        fs_d    = 1'b0;
        wr_en   = 1'b0;

        case (state_q)
            StIdle: begin
                if (!iFVAL) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (iFVAL && !fval_q) begin
                    state_d = StFirst;
                    col_d   = '0;
                    row_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StFirst, StActive: begin
                // Frame end wins over a coincident line end; the partial line is dropped.
                if (!iFVAL) begin
                    state_d = StArmed;
                    dval_d  = 1'b0;
                end else if (dv) begin
                    if (in_line) begin
                        wr_en = 1'b1;
                        col_d = col_q + 1'b1;
                        if (state_q == StFirst && col_q == '0) begin
                            fs_d = 1'b1;
                        end
                        if (state_q == StActive) begin
                            bin_d = 1'b1;
                            d0_d  = iDATA;
                            d1_d  = mem_rd;
                            x_d   = col_q[0] ^ X_PHASE;
                            y_d   = row_q[0] ^ Y_PHASE;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (dval_q) begin
                    row_d   = row_q + 1'b1;
                    col_d   = '0;
                    state_d = StActive;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
            fval_q  <= 1'b0;
            dval_q  <= 1'b0;
            d0_q    <= '0;
            d1_q    <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            bin_q   <= 1'b0;
            rgb_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
            fval_q  <= fval_d;
            dval_q  <= dval_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bin_q   <= bin_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;
        end
    end

    // Read-before-write: mem_rd is sampled into d1_q on the same edge that overwrites it.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            line_mem[addr] <= iDATA;
        end
    end

    assign oD0          = d0_q;
    assign oD1          = d1_q;
    assign oX           = x_q;
    assign oY           = y_q;
    assign oBIN_VAL     = bin_q;
    assign oRGB_VAL     = rgb_q;
    assign oFRAME_START = fs_q;
    assign oROW         = row_q;
    assign oOVF         = ovf_q;

endmodule

// File: tb/tb_bayer_bin_stream_ctrl.sv
// Directed bench: three instances (default, inverted phase, 4-pixel line buffer) share one
// stimulus stream; a per-instance scoreboard queue holds the expected binning beats.
module tb_bayer_bin_stream_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       iFVAL = 1'b0;
    logic       iDVAL = 1'b0;
    logic [9:0] iDATA = '0;

    always #5 CLK = ~CLK;

    logic [9:0]  d0 [3];
    logic [9:0]  d1 [3];
    logic        ox [3];
    logic        oy [3];
    logic        bin [3];
    logic        rgb [3];
    logic        fs [3];
    logic        ovf [3];
    logic [11:0] row [3];

    bayer_bin_stream_ctrl u0 (
        .CLK(CLK), .RESET_N(RESET_N), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
        .oD0(d0[0]), .oD1(d1[0]), .oX(ox[0]), .oY(oy[0]), .oBIN_VAL(bin[0]),
        .oRGB_VAL(rgb[0]), .oFRAME_START(fs[0]), .oROW(row[0]), .oOVF(ovf[0])
    );

    bayer_bin_stream_ctrl #(.X_PHASE(1'b1), .Y_PHASE(1'b1)) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
        .oD0(d0[1]), .oD1(d1[1]), .oX(ox[1]), .oY(oy[1]), .oBIN_VAL(bin[1]),
        .oRGB_VAL(rgb[1]), .oFRAME_START(fs[1]), .oROW(row[1]), .oOVF(ovf[1])
    );

    bayer_bin_stream_ctrl #(.MAX_WIDTH(4), .COL_W(2)) u2 (
        .CLK(CLK), .RESET_N(RESET_N), .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
        .oD0(d0[2]), .oD1(d1[2]), .oX(ox[2]), .oY(oy[2]), .oBIN_VAL(bin[2]),
        .oRGB_VAL(rgb[2]), .oFRAME_START(fs[2]), .oROW(row[2]), .oOVF(ovf[2])
    );

    typedef struct packed {
        logic [9:0] d0;
        logic [9:0] d1;
        logic       x;
        logic       y;
    } exp_t;

    exp_t       sbq [3][$];
    exp_t       mon_e;
    int         n_pass = 0;
    int         n_total = 0;
    int         fs_cnt [3] = '{0, 0, 0};
    int         bin_cnt [3] = '{0, 0, 0};
    logic       bin_prev [3] = '{1'b0, 1'b0, 1'b0};
    logic [9:0] mmem [3][64];
    int         maxw [3] = '{1024, 1024, 4};
    bit         xph [3] = '{1'b0, 1'b1, 1'b0};
    bit         yph [3] = '{1'b0, 1'b1, 1'b0};
    bit         m_active = 1'b0;
    bit         m_first = 1'b0;
    int         m_row = 0;
    bit         m_ovf [3] = '{1'b0, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: pops one expected beat per oBIN_VAL and checks the RGB lag.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            for (int k = 0; k < 3; k++) bin_prev[k] = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rgb_lag[%0d]", k), rgb[k], bin_prev[k]);
                if (fs[k]) fs_cnt[k]++;
                if (bin[k]) begin
                    bin_cnt[k]++;
                    if (sbq[k].size() == 0) begin
                        chk($sformatf("unexpected_bin[%0d]", k), bin[k], 1'b0);
                    end else begin
                        mon_e = sbq[k].pop_front();
                        chk($sformatf("d0[%0d]", k), d0[k], mon_e.d0);
                        chk($sformatf("d1[%0d]", k), d1[k], mon_e.d1);
                        chk($sformatf("x[%0d]", k), ox[k], mon_e.x);
                        chk($sformatf("y[%0d]", k), oy[k], mon_e.y);
                    end
                end
                bin_prev[k] = bin[k];
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_d0"}, d0[0], 0);
        chk({tag, "_d1"}, d1[0], 0);
        chk({tag, "_x"}, ox[0], 0);
        chk({tag, "_y"}, oy[0], 0);
        chk({tag, "_bin"}, bin[0], 0);
        chk({tag, "_rgb"}, rgb[0], 0);
        chk({tag, "_fs"}, fs[0], 0);
        chk({tag, "_row"}, row[0], 0);
        chk({tag, "_ovf"}, ovf[0], 0);
    endtask

    task automatic frame_begin();
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        tick();
        tick();
        iFVAL = 1'b1;
        tick();
        m_active = 1'b1;
        m_first  = 1'b1;
        m_row    = 0;
        for (int k = 0; k < 3; k++) begin
            m_ovf[k]   = 1'b0;
            fs_cnt[k]  = 0;
            bin_cnt[k] = 0;
            chk($sformatf("ovf_clear[%0d]", k), ovf[k], 0);
        end
        chk("row_restart", row[0], 0);
        tick();
    endtask

    task automatic pixels(input int n, input bit rnd);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            iDVAL = 1'b1;
            iDATA = rnd ? 10'($urandom_range(0, 1023)) : 10'(16 * m_row + c);
            if (m_active) begin
                for (int k = 0; k < 3; k++) begin
                    if (c < maxw[k]) begin
                        if (!m_first) begin
                            e.d0 = iDATA;
                            e.d1 = mmem[k][c];
                            e.x  = c[0] ^ xph[k];
                            e.y  = m_row[0] ^ yph[k];
                            sbq[k].push_back(e);
                        end
                        mmem[k][c] = iDATA;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end
            end
            tick();
            for (int k = 0; k < 3; k++) chk($sformatf("ovf[%0d]", k), ovf[k], m_ovf[k]);
            chk("row_in_line", row[0], m_row);
        end
    endtask

    task automatic line_end();
        iDVAL = 1'b0;
        tick();
        if (m_active) begin
            m_row++;
            m_first = 1'b0;
        end
        chk("row_after_line", row[0], m_row);
    endtask

    task automatic frame_end(input int exp_fs);
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        tick();
        m_active = 1'b0;
        tick();
        tick();
        chk("row_at_frame_end", row[0], m_row);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drained[%0d]", k), sbq[k].size(), 0);
            chk($sformatf("fs_count[%0d]", k), fs_cnt[k], exp_fs);
            chk($sformatf("ovf_hold[%0d]", k), ovf[k], m_ovf[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check_all_zero("reset");
        RESET_N = 1'b1;
        tick();

        // Reset mid-line while ACTIVE, then a frame already in progress must be ignored.
        frame_begin();
        pixels(4, 1'b0);
        line_end();
        pixels(2, 1'b0);
        RESET_N = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            sbq[k].delete();
            m_ovf[k]  = 1'b0;
            fs_cnt[k] = 0;
        end
        m_active = 1'b0;
        m_first  = 1'b0;
        m_row    = 0;
        RESET_N  = 1'b1;
        pixels(4, 1'b0);
        line_end();
        pixels(4, 1'b0);
        frame_end(0);

        // 4x3 frame of 16*row+col on all instances; u1 carries the inverted phases.
        frame_begin();
        for (int r = 0; r < 3; r++) begin
            pixels(4, 1'b0);
            line_end();
        end
        frame_end(1);
        chk("bin_pulses_4x3", bin_cnt[0], 8);
        chk("bin_pulses_4x3_phase", bin_cnt[1], 8);

        // 6-pixel lines overflow the 4-deep buffer of u2 only.
        frame_begin();
        pixels(6, 1'b0);
        line_end();
        pixels(6, 1'b0);
        line_end();
        frame_end(1);
        chk("ovf_sticky_u2", ovf[2], 1);
        chk("bin_pulses_sat", bin_cnt[2], 4);

        // Frame drops two pixels into row 2; next frame restarts cleanly.
        frame_begin();
        chk("ovf_cleared_u2", ovf[2], 0);
        pixels(4, 1'b0);
        line_end();
        pixels(4, 1'b0);
        line_end();
        pixels(2, 1'b0);
        frame_end(1);
        chk("row_no_incr_on_drop", row[0], 2);
        frame_begin();
        pixels(4, 1'b0);
        line_end();
        pixels(4, 1'b0);
        line_end();
        frame_end(1);

        // Back-to-back random lines with single-cycle gaps.
        frame_begin();
        for (int r = 0; r < 5; r++) begin
            pixels(8, 1'b1);
            line_end();
        end
        frame_end(1);
        chk("bin_pulses_b2b", bin_cnt[0], 32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bayer_bin_stream_ctrl.md
Name: bayer_bin_stream_ctrl

Overview: Sequences the 2x2 Bayer-binning demosaic stage from a raw single-pixel sensor stream. It holds one line of history in an internal line buffer and presents the current-line and previous-line pixel pair (D0/D1) to the binning datapath. It also generates the column and row parity (X/Y) and produces valid strobes aligned to the datapath's 1-cycle register latency. It sits between the D8M capture front end and the RAW-to-RGB binning block.

Parameters:
MAX_WIDTH, 1024, maximum active pixels per line; sets line buffer depth.
COL_W, 10, column counter width; must satisfy 2^COL_W >= MAX_WIDTH.
ROW_W, 12, row counter width.
X_PHASE, 0, XOR applied to column LSB to give oX (Bayer phase select).
Y_PHASE, 0, XOR applied to row LSB to give oY.

Ports:
CLK  in  1  pixel clock
RESET_N  in  1  asynchronous active-low reset
iFVAL  in  1  frame valid from capture
iDVAL  in  1  pixel valid; high for each active pixel in a line, low between lines
iDATA  in  10  raw Bayer pixel
oD0  out  10  current-line pixel to binning stage
oD1  out  10  previous-line pixel, same column, to binning stage
oX  out  1  column parity to binning stage
oY  out  1  row parity to binning stage
oBIN_VAL  out  1  oD0/oD1/oX/oY valid
oRGB_VAL  out  1  oBIN_VAL delayed 1 cycle; qualifies binning-stage R/G/B
oFRAME_START  out  1  1-cycle pulse on first accepted pixel of a frame
oROW  out  ROW_W  current row index
oOVF  out  1  sticky per frame: a line exceeded MAX_WIDTH

Behaviour:
- Reset (async, RESET_N=0): all outputs 0; counters 0; state IDLE. Line buffer contents are don't-care and are not cleared.
- State IDLE: wait for iFVAL=0, then go to ARMED. Never starts mid-frame.
- State ARMED: on iFVAL 0->1, go to FIRST_LINE; clear row, column and oOVF.
- State FIRST_LINE: each iDVAL=1 cycle writes iDATA to buffer[col] and increments col. oBIN_VAL stays 0 (no valid history). On the iDVAL 1->0 edge: row++, col=0, go to ACTIVE.
- State ACTIVE: each iDVAL=1 cycle does a read-before-write at buffer[col]. The old value is the previous-line pixel; iDATA is written. On the iDVAL falling edge: row++ and col=0.
- Any state except IDLE: iFVAL 1->0 returns to ARMED. Any partial line is discarded.
- Latency: for a pixel accepted at cycle t in ACTIVE, at t+1 the block drives oD0=iDATA(t), oD1=buffer old value, oX=col(t)[0]^X_PHASE, oY=row(t)[0]^Y_PHASE, oBIN_VAL=1. oRGB_VAL=1 at t+2.
- oD0/oD1/oX/oY hold their last values when oBIN_VAL=0.
- oFRAME_START: pulses at t+1 for the first pixel in FIRST_LINE. This is the only cycle it is high per frame.
- Column saturation: when col reaches MAX_WIDTH, further pixels in that line are not written, oBIN_VAL stays 0 for them, col does not wrap, and oOVF is set until the next frame start.
- Row counter wraps modulo 2^ROW_W.
- A 1-cycle iDVAL=0 gap is a line end. No intra-line gaps are supported.
- iDVAL=1 while iFVAL=0 is ignored.
- Simultaneous iDVAL falling edge and iFVAL falling edge: the frame end takes priority; row is not incremented.

Test Plan:
1. Reset mid-line (RESET_N low 3 cycles during ACTIVE) -> all outputs 0 immediately. A frame that begins with iFVAL already high is ignored until iFVAL 0->1.
2. 4x3 frame, pixel value = 16*row+col -> no oBIN_VAL on row 0. Row 1 col 2 gives oD0=18, oD1=2, oX=0, oY=1. oRGB_VAL lags oBIN_VAL by exactly 1 cycle. 8 oBIN_VAL pulses total.
3. X_PHASE=1, Y_PHASE=1, same frame -> oX/oY inverted versus scenario 2 on every valid beat.
4. MAX_WIDTH=4, line of 6 pixels -> oOVF=1 after pixel 4. Next line reads the first 4 stored values correctly. oOVF clears at the next frame start.
5. iFVAL drops after 2 pixels of row 2 -> state returns to ARMED, no further oBIN_VAL. Next frame: oFRAME_START pulses once and oROW restarts at 0.
6. Back-to-back lines with 1-cycle gap at 1 pixel/clock -> no dropped pixels; oD1 matches the previous line column-for-column.
